// File: rtl/vae_rng_pkg.sv
// Shared definitions for the VAE random-sampling chain (RNG, Gaussian sampler,
// reparameterisation unit).
package vae_rng_pkg;

    // Width of the uniform byte produced by the XORShift generator
    localparam int RNG_W = 8;

    // Width of the signed epsilon sample fed to the reparameterisation stage
    localparam int EPS_W = 16;

    // Midpoint of one uniform byte; a sum of N bytes is centred on N*MID
    localparam int MID = 2 ** (RNG_W - 1);

    // Ceiling log2 usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/clt_gauss_sampler.sv
// Central-limit Gaussian sampler: sums N_SUM uniform bytes and removes the
// midpoint to produce a zero-centred, approximately normal epsilon sample.
module clt_gauss_sampler
    import vae_rng_pkg::*;
#(
    parameter int IN_W  = RNG_W,
    parameter int N_SUM = 4,
    parameter int OUT_W = EPS_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    u_valid,
    input  logic [IN_W-1:0]         u_data,
    output logic                    u_ready,
    output logic                    eps_valid,
    output logic [OUT_W-1:0]        eps_data,
    input  logic                    eps_ready,
    output logic [clog2(N_SUM):0]   acc_cnt
);

    localparam int LOG_N = clog2(N_SUM);
    localparam int ACC_W = IN_W + LOG_N;
    localparam int CNT_W = LOG_N + 1;

    // Count value at which the next accepted byte completes a group
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SUM - 1);

    // N_SUM * 2^(IN_W-1), held one bit wider than the accumulator so the
    // subtraction below can go negative
    localparam logic [ACC_W:0] MID_SUM = (ACC_W + 1)'(N_SUM * (2 ** (IN_W - 1)));

    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    final_byte;
    logic [ACC_W-1:0]        sum_next;
    logic signed [ACC_W:0]   centred;
    logic signed [OUT_W-1:0] eps_next;

    // The final byte waits while the output register is still occupied;
    // earlier bytes of the next group flow in regardless of backpressure
    assign final_byte = (cnt == LAST_CNT);
    assign u_ready    = !(final_byte && eps_valid);
    assign accept     = u_valid && u_ready;
    assign acc_cnt    = cnt;

    // Running sum including the byte on the input, then recentred and sign-extended
    always_comb begin
        sum_next = acc + ACC_W'(u_data);
        centred  = $signed({1'b0, sum_next} - MID_SUM);
        eps_next = OUT_W'(centred);
    end

    // Partial-sum accumulator and byte counter; clear drops the group in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (final_byte) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output register: loads on the final byte, empties on the downstream handshake.
    // A load and a drain never share an edge because the final byte stalls while valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            eps_valid <= 1'b0;
            eps_data  <= '0;
        end else begin
            if (eps_valid && eps_ready) begin
                eps_valid <= 1'b0;
            end
            if (!clear && accept && final_byte) begin
                eps_valid <= 1'b1;
                eps_data  <= eps_next;
            end
        end
    end

endmodule

// File: tb/tb_clt_gauss_sampler.sv
// Self-checking bench for clt_gauss_sampler: a cycle model pushes expected
// samples to a scoreboard queue as bytes are driven; DUT outputs are checked
// against the queue head and against hand-derived constants.
module tb_clt_gauss_sampler;
    import vae_rng_pkg::*;

    localparam int N_SUM = 4;
    localparam int IN_W  = RNG_W;
    localparam int OUT_W = EPS_W;
    localparam int CNT_W = clog2(N_SUM) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             u_valid;
    logic [IN_W-1:0]  u_data;
    logic             u_ready;
    logic             eps_valid;
    logic [OUT_W-1:0] eps_data;
    logic             eps_ready;
    logic [CNT_W-1:0] acc_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state and scoreboard
    int               m_acc = 0;
    int               m_cnt = 0;
    bit               m_valid = 1'b0;
    logic [OUT_W-1:0] exp_q[$];
    bit               last_acc = 1'b0;

    // 10 ns clock
    always #5 clk = ~clk;

    clt_gauss_sampler #(
        .IN_W (IN_W),
        .N_SUM(N_SUM),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .u_valid  (u_valid),
        .u_data   (u_data),
        .u_ready  (u_ready),
        .eps_valid(eps_valid),
        .eps_data (eps_data),
        .eps_ready(eps_ready),
        .acc_cnt  (acc_cnt)
    );

    function automatic bit model_ready();
        return !(m_cnt == N_SUM - 1 && m_valid);
    endfunction

    function automatic logic [OUT_W-1:0] q_head();
        if (exp_q.size() == 0) return 'x;
        return exp_q[0];
    endfunction

    function automatic logic [7:0] xorshift(input logic [7:0] s);
        logic [7:0] t;
        t = s;
        t = t ^ (t << 7);
        t = t ^ (t >> 5);
        t = t ^ (t << 3);
        return t;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later
    task automatic cycle(input bit v, input logic [IN_W-1:0] d, input bit er,
                         input bit c, input bit rs);
        bit rdy;
        rst = rs; u_valid = v; u_data = d; eps_ready = er; clear = c;
        rdy = model_ready();
        last_acc = 1'b0;
        if (rs) begin
            m_acc = 0; m_cnt = 0; m_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (m_valid && er) begin
                m_valid = 1'b0;
                void'(exp_q.pop_front());
            end
            if (c) begin
                m_acc = 0; m_cnt = 0;
            end else if (v && rdy) begin
                last_acc = 1'b1;
                if (m_cnt == N_SUM - 1) begin
                    exp_q.push_back(OUT_W'(m_acc + int'(d) - N_SUM * MID));
                    m_valid = 1'b1;
                    m_acc = 0; m_cnt = 0;
                end else begin
                    m_acc = m_acc + int'(d);
                    m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (eps_valid !== 1'b0) begin errors++; $display("FAIL reset_eps_valid: got %b want 0", eps_valid); end
        checks++;
        if (eps_data !== 16'h0000) begin errors++; $display("FAIL reset_eps_data: got %h want 0000", eps_data); end
        checks++;
        if (acc_cnt !== '0) begin errors++; $display("FAIL reset_acc_cnt: got %0d want 0", acc_cnt); end
        checks++;
        if (u_ready !== 1'b1) begin errors++; $display("FAIL reset_u_ready: got %b want 1", u_ready); end
    endtask

    task automatic test_midpoint();
        for (int i = 0; i < N_SUM; i++) begin
            checks++;
            if (acc_cnt !== CNT_W'(i) || eps_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_progress: acc_cnt=%0d eps_valid=%b want %0d/0", acc_cnt, eps_valid, i);
            end
            cycle(1'b1, 8'd128, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (eps_valid !== 1'b1 || eps_data !== q_head() || eps_data !== 16'h0000) begin
            errors++;
            $display("FAIL mid_sample: valid=%b data=%h want 1/%h", eps_valid, eps_data, q_head());
        end
        checks++;
        if (acc_cnt !== '0) begin errors++; $display("FAIL mid_acc_cnt: got %0d want 0", acc_cnt); end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (eps_valid !== 1'b0) begin errors++; $display("FAIL mid_drain: eps_valid=%b want 0", eps_valid); end
    endtask

    task automatic test_extremes();
        logic [7:0]  pat  [2];
        logic [15:0] want [2];
        pat[0] = 8'd255; want[0] = 16'h01FC;
        pat[1] = 8'd0;   want[1] = 16'hFE00;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N_SUM; i++) cycle(1'b1, pat[k], 1'b1, 1'b0, 1'b0);
            checks++;
            if (eps_valid !== 1'b1 || eps_data !== want[k] || eps_data !== q_head()) begin
                errors++;
                $display("FAIL extreme_%0d: valid=%b data=%h want 1/%h", k, eps_valid, eps_data, want[k]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            checks++;
            if (u_ready !== model_ready()) begin
                errors++;
                $display("FAIL bp_u_ready: cycle %0d got %b want %b", cyc, u_ready, model_ready());
            end
            cycle(sent < 8, 8'd10, 1'b0, 1'b0, 1'b0);
            if (last_acc) sent++;
            if (m_valid) begin
                checks++;
                if (eps_valid !== 1'b1 || eps_data !== 16'hFE28) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d valid=%b data=%h want 1/fe28", cyc, eps_valid, eps_data);
                end
            end
        end
        checks++;
        if (u_ready !== 1'b0 || acc_cnt !== CNT_W'(3)) begin
            errors++;
            $display("FAIL bp_stall: u_ready=%b acc_cnt=%0d want 0/3", u_ready, acc_cnt);
        end
        checks++;
        if (eps_data !== q_head()) begin errors++; $display("FAIL bp_first: got %h want %h", eps_data, q_head()); end
        cycle(1'b1, 8'd10, 1'b1, 1'b0, 1'b0);
        checks++;
        if (eps_valid !== 1'b0 || u_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_drain: valid=%b u_ready=%b want 0/1", eps_valid, u_ready);
        end
        cycle(1'b1, 8'd10, 1'b1, 1'b0, 1'b0);
        checks++;
        if (eps_valid !== 1'b1 || eps_data !== 16'hFE28 || eps_data !== q_head()) begin
            errors++;
            $display("FAIL bp_second: valid=%b data=%h want 1/fe28", eps_valid, eps_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        cycle(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
        checks++;
        if (acc_cnt !== CNT_W'(2)) begin errors++; $display("FAIL clear_pre: acc_cnt=%0d want 2", acc_cnt); end
        cycle(1'b1, 8'd50, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc_cnt !== '0 || eps_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_post: acc_cnt=%0d valid=%b want 0/0", acc_cnt, eps_valid);
        end
        for (int i = 0; i < N_SUM; i++) cycle(1'b1, 8'd128, 1'b1, 1'b0, 1'b0);
        checks++;
        if (eps_valid !== 1'b1 || eps_data !== 16'h0000 || eps_data !== q_head()) begin
            errors++;
            $display("FAIL clear_sample: valid=%b data=%h want 1/0000", eps_valid, eps_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N_SUM + 2; i++) cycle(1'b1, 8'd100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (eps_valid !== 1'b1 || acc_cnt !== CNT_W'(2)) begin
            errors++;
            $display("FAIL rstmid_pre: valid=%b acc_cnt=%0d want 1/2", eps_valid, acc_cnt);
        end
        cycle(1'b1, 8'd100, 1'b1, 1'b0, 1'b1);
        checks++;
        if (eps_valid !== 1'b0 || acc_cnt !== '0 || u_ready !== 1'b1 || eps_data !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_post: valid=%b acc_cnt=%0d u_ready=%b data=%h want 0/0/1/0000",
                     eps_valid, acc_cnt, u_ready, eps_data);
        end
        for (int i = 0; i < N_SUM; i++) cycle(1'b1, 8'd128, 1'b1, 1'b0, 1'b0);
        checks++;
        if (eps_valid !== 1'b1 || eps_data !== 16'h0000 || eps_data !== q_head()) begin
            errors++;
            $display("FAIL rstmid_sample: valid=%b data=%h want 1/0000", eps_valid, eps_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 4 * N_SUM; i++) begin
            d = 8'($urandom_range(0, 255));
            cycle(1'b1, d, 1'b1, 1'b0, 1'b0);
            checks++;
            if (eps_valid !== ((i % N_SUM) == N_SUM - 1)) begin
                errors++;
                $display("FAIL b2b_rate: cycle %0d valid=%b", i, eps_valid);
            end
            if (eps_valid === 1'b1) begin
                checks++;
                if (eps_data !== q_head()) begin
                    errors++;
                    $display("FAIL b2b_data: cycle %0d got %h want %h", i, eps_data, q_head());
                end
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_rng();
        logic [7:0]       x;
        logic [OUT_W-1:0] held;
        bit               stalled;
        bit               er;
        int               got;
        int               cyc;
        x = 8'h4D; held = '0; stalled = 1'b0; got = 0; cyc = 0;
        while (got < 4096 && cyc < 60000) begin
            er = ($urandom_range(0, 1) == 1);
            checks++;
            if (u_ready !== model_ready() || eps_valid !== m_valid) begin
                errors++;
                $display("FAIL rng_handshake: cycle %0d u_ready=%b valid=%b want %b/%b",
                         cyc, u_ready, eps_valid, model_ready(), m_valid);
            end
            if (eps_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (eps_data !== held) begin
                        errors++;
                        $display("FAIL rng_stable: cycle %0d got %h want %h", cyc, eps_data, held);
                    end
                end
                checks++;
                if (eps_data !== q_head() || $signed(eps_data) < -512 || $signed(eps_data) > 508) begin
                    errors++;
                    $display("FAIL rng_sample: cycle %0d got %h want %h in [-512,508]", cyc, eps_data, q_head());
                end
                if (er) got++;
                held = eps_data;
            end
            stalled = (eps_valid === 1'b1) && !er;
            cycle(1'b1, x, er, 1'b0, 1'b0);
            if (last_acc) x = xorshift(x);
            cyc++;
        end
        checks++;
        if (got != 4096) begin
            errors++;
            $display("FAIL rng_timeout: got %0d samples want 4096", got);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; u_valid = 1'b0; u_data = '0; eps_ready = 1'b0;
        test_reset();
        test_midpoint();
        test_extremes();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_rng();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
